fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate generator and decode logic.
- Holds the PC and issues one word request at a time to instruction memory over a request/grant/response handshake.
- Registers the returned word together with its PC for the decode stage. Supports stall from decode, redirect from branch/jump resolution, and a one-entry skid buffer so a response is never lost while decode is stalled.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage with a one-entry skid buffer
//   clk, rst                 clock; asynchronous active-low reset
//   imem_req/addr/gnt        request handshake to instruction memory
//   imem_rvalid/rdata        response from instruction memory
//   stall                    decode cannot accept the held instruction
//   redirect/redirect_pc     taken branch/jump target (one-cycle pulse)
//   instr/instr_pc/valid     registered instruction and its address for decode
//   misaligned               one-cycle pulse for a redirect target with nonzero low bits
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        misaligned
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, instr_n, instr_pc_n, skid, skid_n, skid_pc, skid_pc_n;
    logic        instr_valid_n, misaligned_n, slot_free;
    assign imem_req  = rst && state == S_FETCH;
    assign imem_addr = pc;
    assign slot_free = !instr_valid || !stall;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            skid        <= '0;
            skid_pc     <= '0;
            misaligned  <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= instr_valid_n;
            skid        <= skid_n;
            skid_pc     <= skid_pc_n;
            misaligned  <= misaligned_n;
        end
    end
    // pc already points past the outstanding word, so its address is pc - PC_STEP.
    // The skid buffer is occupied exactly while in S_HOLD.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        instr_pc_n    = instr_pc;
        skid_n        = skid;
        skid_pc_n     = skid_pc;
        instr_valid_n = instr_valid && stall;
        misaligned_n  = 1'b0;
        if (redirect) begin
            pc_n          = {redirect_pc[31:2], 2'b00};
            instr_valid_n = 1'b0;
            misaligned_n  = |redirect_pc[1:0];
            state_n       = ((state == S_FETCH && imem_gnt) ||
                             ((state == S_WAIT || state == S_DROP) && !imem_rvalid)) ? S_DROP : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_gnt) begin
                        pc_n    = pc + PC_STEP;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && slot_free) begin
                        instr_n       = imem_rdata;
                        instr_pc_n    = pc - PC_STEP;
                        instr_valid_n = 1'b1;
                        state_n       = S_FETCH;
                    end else if (imem_rvalid) begin
                        skid_n    = imem_rdata;
                        skid_pc_n = pc - PC_STEP;
                        state_n   = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        instr_n       = skid;
                        instr_pc_n    = skid_pc;
                        instr_valid_n = 1'b1;
                        state_n       = S_FETCH;
                    end
                end
                default: begin
                    if (imem_rvalid) state_n = S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against an address-stream model
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid, stall, redirect;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
    logic        instr_valid, misaligned;

    fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int delivered = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // stimulus knobs
    int unsigned p_gnt = 100, p_stall = 0, p_redir = 0, kmin = 1, kmax = 1;
    bit          hold_gnt = 0, force_stall = 0, req_redir = 0;
    logic [31:0] req_target = '0;

    // memory responder and control driver, inputs change 1 time unit after each rising edge
    bit          pend = 0;
    int unsigned cnt = 0;
    logic [31:0] paddr = '0, tgt;
    initial begin
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 0;
            imem_rdata  = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1;
                    imem_rdata  = mem(paddr);
                    pend        = 0;
                end
            end
            imem_gnt = 0;
            if (imem_req && !pend && !hold_gnt && $urandom_range(99) < p_gnt) begin
                imem_gnt = 1;
                pend     = 1;
                paddr    = imem_addr;
                cnt      = $urandom_range(kmax, kmin);
            end
            stall    = force_stall || ($urandom_range(99) < p_stall);
            redirect = 0;
            if (req_redir) begin
                redirect    = 1;
                redirect_pc = req_target;
                req_redir   = 0;
            end else if ($urandom_range(99) < p_redir) begin
                tgt = $urandom;
                case ($urandom_range(2))
                    0:       tgt = tgt & 32'h0000_0FFF;
                    1:       tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
                    default: tgt = tgt & 32'hFFFF_FFFC;
                endcase
                redirect    = 1;
                redirect_pc = tgt;
            end
        end
    end

    // reference model: the program stream is the granted addresses in order; a redirect
    // discards everything granted but not yet consumed and restarts at the aligned target
    logic [31:0] q[$];
    logic [31:0] npc = RST_PC, a;
    bit          prv_red = 0, prv_mis = 0;
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            npc     = RST_PC;
            prv_red = 0;
            prv_mis = 0;
        end else begin
            if (imem_req) chk(imem_addr == npc, "imem_addr", imem_addr, npc);
            chk(misaligned == prv_mis, "misaligned", 32'(misaligned), 32'(prv_mis));
            if (prv_red) chk(!instr_valid, "valid_after_redirect", 32'(instr_valid), 32'd0);
            if (instr_valid && !stall) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_instr", instr_pc, 32'hFFFF_FFFF);
                end else begin
                    a = q.pop_front();
                    chk(instr_pc == a, "instr_pc", instr_pc, a);
                    chk(instr == mem(a), "instr", instr, mem(a));
                    delivered++;
                end
            end
            if (imem_req && imem_gnt) begin
                q.push_back(npc);
                npc = npc + 32'd4;
            end
            if (redirect) begin
                q.delete();
                npc = {redirect_pc[31:2], 2'b00};
            end
            prv_red = redirect;
            prv_mis = redirect && (redirect_pc[1:0] != 2'b00);
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) ok = 1;
        end
    endtask

    bit ok, seen;
    int lat;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk(!imem_req && !instr_valid && !misaligned, "reset_outputs",
            {29'd0, imem_req, instr_valid, misaligned}, 32'd0);
        #1 rst = 1;
        // first-fetch latency with same-cycle grant and one-cycle response
        wait_grant(ok);
        chk(ok, "first_grant", 32'(ok), 32'd1);
        lat = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (instr_valid) seen = 1;
        end
        chk(lat == 2, "first_latency", lat, 32'd2);
        chk(instr_pc == RST_PC && instr == mem(RST_PC), "first_instr", instr, mem(RST_PC));
        // fill output register and skid buffer, then misaligned redirect under stall
        repeat (5) @(negedge clk);
        force_stall = 1;
        repeat (8) @(negedge clk);
        chk(!imem_req, "no_req_when_full", 32'(imem_req), 32'd0);
        chk(instr_valid, "held_valid", 32'(instr_valid), 32'd1);
        req_target = 32'h0000_0203;
        req_redir  = 1;
        @(negedge clk);
        @(negedge clk);
        chk(misaligned, "misaligned_pulse", 32'(misaligned), 32'd1);
        chk(!instr_valid, "flush_valid", 32'(instr_valid), 32'd0);
        chk(imem_req && imem_addr == 32'h200, "redirect_addr", imem_addr, 32'h200);
        force_stall = 0;
        repeat (10) @(negedge clk);
        // redirect while a request is outstanding: its response must be dropped
        kmin = 3; kmax = 3;
        wait_grant(ok);
        chk(ok, "wait_grant", 32'(ok), 32'd1);
        req_target = 32'h0000_0100;
        req_redir  = 1;
        repeat (15) @(negedge clk);
        // address wrap at the top of memory
        kmin = 1; kmax = 1;
        req_target = 32'hFFFF_FFF8;
        req_redir  = 1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == 32'hFFFF_FFFC) seen = 1;
        end
        chk(seen, "wrap_top_word", 32'(seen), 32'd1);
        repeat (8) @(negedge clk);
        // asynchronous reset during S_WAIT, stale response afterwards
        kmin = 6; kmax = 6;
        wait_grant(ok);
        chk(ok, "reset_grant", 32'(ok), 32'd1);
        hold_gnt = 1;
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk(!instr_valid && !imem_req, "async_reset", {30'd0, instr_valid, imem_req}, 32'd0);
        @(negedge clk);
        #2 rst = 1;
        repeat (7) @(negedge clk);
        chk(imem_req && imem_addr == RST_PC, "stale_ignored_addr", imem_addr, RST_PC);
        chk(!instr_valid, "stale_ignored_valid", 32'(instr_valid), 32'd0);
        hold_gnt = 0;
        // randomized traffic
        p_gnt = 60; kmin = 1; kmax = 3; p_stall = 30; p_redir = 4;
        repeat (3000) @(negedge clk);
        p_gnt = 100; kmin = 1; kmax = 1; p_stall = 50; p_redir = 2;
        repeat (2000) @(negedge clk);
        p_redir = 0; p_stall = 0;
        repeat (20) @(negedge clk);
        chk(delivered > 300, "liveness", delivered, 32'd300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
